// File: rtl/controller_sequencer_if.sv
// controller_sequencer_if
// Control bundle between the SAP-1 controller/sequencer and its datapath.
//   opcode   : IR upper nibble (datapath -> controller)
//   t_state  : one-hot ring state, bit0 = T1 .. bit5 = T6
//   pc_inc, pc_en, mar_load, ram_en, ir_load, ir_en, a_load, a_en,
//   alu_sub, alu_en, b_load, out_load : active-high control lines
//   halted   : machine stopped by HLT
// Modports: master = controller side, slave = datapath side.
interface controller_sequencer_if;
    logic [3:0] opcode;
    logic [5:0] t_state;
    logic       pc_inc;
    logic       pc_en;
    logic       mar_load;
    logic       ram_en;
    logic       ir_load;
    logic       ir_en;
    logic       a_load;
    logic       a_en;
    logic       alu_sub;
    logic       alu_en;
    logic       b_load;
    logic       out_load;
    logic       halted;

    modport master (
        input  opcode,
        output t_state, pc_inc, pc_en, mar_load, ram_en, ir_load, ir_en,
               a_load, a_en, alu_sub, alu_en, b_load, out_load, halted
    );

    modport slave (
        output opcode,
        input  t_state, pc_inc, pc_en, mar_load, ram_en, ir_load, ir_en,
               a_load, a_en, alu_sub, alu_en, b_load, out_load, halted
    );
endinterface

// File: rtl/controller_sequencer.sv
// controller_sequencer
// SAP-1 controller/sequencer: six-state one-hot ring counter (T1..T6) plus
// instruction decoder driving all datapath load/enable/ALU-mode lines.
// Ports:
//   clk   : system clock, rising-edge
//   reset : synchronous, active-high; overrides everything
//   bus   : controller_sequencer_if.master (opcode in; t_state, controls,
//           halted out)
// Optional feature macro: CTRL_EARLY_FETCH_EN
//   defined   -> LDA returns to T1 after T5, OUT and NOP after T4
//   undefined -> every non-HLT instruction walks all six states
module controller_sequencer (
    input  logic                          clk,
    input  logic                          reset,
    controller_sequencer_if.master        bus
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    t_state_e state;
    logic     halted;

    logic is_lda, is_add, is_sub, is_out, is_hlt, is_nop;

    always_comb begin
        is_lda = (bus.opcode == OP_LDA);
        is_add = (bus.opcode == OP_ADD);
        is_sub = (bus.opcode == OP_SUB);
        is_out = (bus.opcode == OP_OUT);
        is_hlt = (bus.opcode == OP_HLT);
        is_nop = !(is_lda || is_add || is_sub || is_out || is_hlt);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= T1;
            halted <= 1'b0;
        end else if (!halted) begin
            case (state)
                T1: state <= T2;
                T2: state <= T3;
                T3: state <= T4;
                T4: begin
                    // HLT freezes the ring in T4; only reset releases it.
                    if (is_hlt) begin
                        halted <= 1'b1;
`ifdef CTRL_EARLY_FETCH_EN
                    end else if (is_out || is_nop) begin
                        state <= T1;
`endif
                    end else begin
                        state <= T5;
                    end
                end
                T5: begin
`ifdef CTRL_EARLY_FETCH_EN
                    if (is_lda)
                        state <= T1;
                    else
                        state <= T6;
`else
                    state <= T6;
`endif
                end
                T6:      state <= T1;
                default: state <= T1;
            endcase
        end
    end

    always_comb begin
        bus.pc_inc   = 1'b0;
        bus.pc_en    = 1'b0;
        bus.mar_load = 1'b0;
        bus.ram_en   = 1'b0;
        bus.ir_load  = 1'b0;
        bus.ir_en    = 1'b0;
        bus.a_load   = 1'b0;
        bus.a_en     = 1'b0;
        bus.alu_sub  = 1'b0;
        bus.alu_en   = 1'b0;
        bus.b_load   = 1'b0;
        bus.out_load = 1'b0;
        if (!halted) begin
            case (state)
                T1: begin
                    bus.pc_en    = 1'b1;
                    bus.mar_load = 1'b1;
                end
                T2: bus.pc_inc = 1'b1;
                T3: begin
                    bus.ram_en  = 1'b1;
                    bus.ir_load = 1'b1;
                end
                T4: begin
                    if (is_lda || is_add || is_sub) begin
                        bus.ir_en    = 1'b1;
                        bus.mar_load = 1'b1;
                    end else if (is_out) begin
                        bus.a_en     = 1'b1;
                        bus.out_load = 1'b1;
                    end
                end
                T5: begin
                    if (is_lda) begin
                        bus.ram_en = 1'b1;
                        bus.a_load = 1'b1;
                    end else if (is_add || is_sub) begin
                        bus.ram_en = 1'b1;
                        bus.b_load = 1'b1;
                    end
                end
                T6: begin
                    if (is_add || is_sub) begin
                        bus.alu_en  = 1'b1;
                        bus.a_load  = 1'b1;
                        bus.alu_sub = is_sub;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.t_state = state;
    assign bus.halted  = halted;

endmodule

// File: doc/controller_sequencer.md
# controller_sequencer

SAP-1 controller/sequencer: a six-state ring counter (T1–T6) plus an instruction decoder that drives every load, enable and ALU-mode control line in the datapath. It sits directly upstream of the B register, and also feeds the PC, MAR, RAM, IR, accumulator, ALU and output register.

- Sequencing: fetches each instruction in T1–T3, then executes LDA/ADD/SUB/OUT/HLT in T4–T6.
- Halt: stops the machine on HLT until reset.

## Interface
Parameters: none; opcode map fixed.
- LDA = 4'b0000
- ADD = 4'b0001
- SUB = 4'b0010
- OUT = 4'b1110
- HLT = 4'b1111
- All other opcodes = NOP

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; wins over all other activity
- opcode  in  4  IR upper nibble; valid from T4 of each instruction
- t_state  out  6  one-hot ring state, bit0 = T1 … bit5 = T6
- pc_inc  out  1  program counter increment (Cp)
- pc_en  out  1  PC drives w_bus (Ep)
- mar_load  out  1  MAR loads from w_bus (Lm)
- ram_en  out  1  RAM drives w_bus (CE)
- ir_load  out  1  IR loads from w_bus (Li)
- ir_en  out  1  IR operand nibble drives w_bus (Ei)
- a_load  out  1  accumulator loads from w_bus (La)
- a_en  out  1  accumulator drives w_bus (Ea)
- alu_sub  out  1  ALU subtract mode (Su)
- alu_en  out  1  ALU result drives w_bus (Eu)
- b_load  out  1  B register loads from w_bus (Lb)
- out_load  out  1  output register loads from w_bus (Lo)
- halted  out  1  machine stopped by HLT

## Operation
- Registered state: t_state (one-hot) and halted.
- All control outputs are combinational decodes of t_state, opcode and halted. All are active-high.
- Every control not listed for a state is 0.

Fetch (all opcodes):
- T1: pc_en, mar_load
- T2: pc_inc
- T3: ram_en, ir_load

Execute:
- LDA:
  - T4: ir_en, mar_load
  - T5: ram_en, a_load
  - T6: none
- ADD:
  - T4: ir_en, mar_load
  - T5: ram_en, b_load
  - T6: alu_en, a_load
- SUB: same as ADD, with alu_sub = 1 in T6 only.
- OUT:
  - T4: a_en, out_load
  - T5, T6: none
- NOP: T4–T6 none.

HLT handling:
- In T4 with opcode HLT, all controls are 0 and the ring does not advance.
- halted is set on that edge.
- While halted = 1: t_state holds T4 and all controls are forced to 0, regardless of opcode.

Other rules:
- Ring order: T1→T2→…→T6→T1.
- Bus-exclusivity invariant: at most one of pc_en, ram_en, ir_en, a_en, alu_en is 1 in any cycle.

## Timing
- Reset values (outputs on the cycle after a reset edge):
  - t_state = 6'b000001
  - halted = 0
  - pc_en = mar_load = 1
  - all other controls = 0
- Reset mid-instruction or while halted returns to T1 on the same edge. Opcode is ignored.
- Each T-state lasts exactly one clock. Destination registers load on the rising edge that ends the state asserting their load line. The ring advances on that same edge.
- Opcode is captured by the IR at the end of T3. The controller treats it as valid from T4 through T6 and ignores it in T1–T3.
- Instruction period is 6 clocks, except HLT (terminal) and the Configuration option below.

## Configuration
- Macro: CTRL_EARLY_FETCH_EN
- Defined (variable machine cycle):
  - LDA: T5→T1 (5 clocks)
  - OUT: T4→T1 (4 clocks)
  - NOP: T3→T4→T1 (4 clocks)
  - ADD/SUB: unchanged, 6 clocks
  - HLT: unchanged
- Undefined: every non-HLT instruction takes all 6 states; no early return.

## Test plan
- Reset: assert reset 2 clocks, opcode = 4'hX. Expected: t_state = 000001, pc_en = mar_load = 1, halted = 0. Then deassert reset and run 3 clocks: t_state steps 000010 (pc_inc = 1), then 000100 (ram_en = ir_load = 1).
- ADD: opcode = 0001.
  - T4: ir_en = mar_load = 1
  - T5: ram_en = b_load = 1
  - T6: alu_en = a_load = 1, alu_sub = 0
  - Next clock: t_state = 000001
- SUB/LDA: opcode = 0010 gives alu_sub = 1 only in T6. opcode = 0000 gives a_load = 1 in T5 and no controls in T6. Bus-exclusivity checker passes every cycle.
- HLT: opcode = 1111 at T4.
  - All controls 0, halted = 1 after the edge.
  - t_state stays 001000 for 20 clocks while opcode toggles 0000/0001.
  - Then assert reset: t_state = 000001, halted = 0.
- Reset mid-instruction: reset asserted during T5 of ADD. Expected: next cycle t_state = 000001, b_load = 0, pc_en = mar_load = 1.
- CTRL_EARLY_FETCH_EN defined:
  - OUT sequence: t_state 000001, 000010, 000100, 001000 (a_en = out_load = 1), then 000001 — period 4.
  - LDA period 5.
  - Undefined build: both instructions have period 6.
